// File: rtl/obuf_slice_pkg.sv
// Shared interconnect types for the outbound register slice.
// Holds the slice state encoding and its occupancy decode.
package obuf_slice_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } obuf_state_t;

    localparam int unsigned OCC_W = 2;

    function automatic logic [OCC_W-1:0] occ_of(input obuf_state_t s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/obuf_slice_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Shared by interconnect blocks for stall/event statistics.
module sat_cnt #(
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + CW'(1);
        end
    end

endmodule

// File: rtl/obuf_slice.sv
// Outbound valid/busy register slice: main + skid register, every output a flop.
// Breaks combinational paths from the IP's valid/data and from the bus busy.
module obuf_slice
    import obuf_slice_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [DW-1:0]    ip_data_i,
    input  logic             ip_vld_i,
    output logic             ip_busy_o,
    output logic [DW-1:0]    bus_data_o,
    output logic             bus_vld_o,
    input  logic             bus_busy_i,
    output logic [OCC_W-1:0] occupancy_o,
    output logic [CW-1:0]    stall_cnt_o
);

    obuf_state_t   state_q;
    obuf_state_t   state_d;
    logic [DW-1:0] skid_q;
    logic          acc;
    logic          in_xfer;
    logic          load_main;
    logic          load_skid;
    logic          main_from_skid;
    logic          stall_inc;

    assign acc       = bus_vld_o & ~bus_busy_i;
    assign in_xfer   = ip_vld_i & ~ip_busy_o;
    assign stall_inc = bus_vld_o & bus_busy_i;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_xfer && acc) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (acc) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (acc) begin
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Flag outputs are registered from next state so they stay pure flops yet track the FSM.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= EMPTY;
            bus_data_o  <= '0;
            skid_q      <= '0;
            bus_vld_o   <= 1'b0;
            ip_busy_o   <= 1'b0;
            occupancy_o <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                bus_data_o <= ip_data_i;
            end else if (main_from_skid) begin
                bus_data_o <= skid_q;
            end
            if (load_skid) begin
                skid_q <= ip_data_i;
            end
            bus_vld_o   <= (state_d != EMPTY);
            ip_busy_o   <= (state_d == FULL);
            occupancy_o <= occ_of(state_d);
        end
    end

    sat_cnt #(
        .CW(CW)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .inc_i  (stall_inc),
        .cnt_o  (stall_cnt_o)
    );

endmodule

// File: doc/obuf_slice.md
# obuf_slice

Transmit-side register slice for the interconnect's valid/busy handshake. It accepts beats from an IP whose valid and data are generated combinationally. It presents them to the bus with valid, data and the back-pressure flag to the IP all driven straight from flops, so no combinational path crosses the block in either direction. It is the outbound counterpart of the inbound skid buffer, and sits between every initiator/responder output channel and the crossbar.

## Interface
- DW, 8, beat data width
- CW, 16, stall counter width
- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- ip_data_i  in  DW  beat data from IP (may be combinational)
- ip_vld_i  in  1  beat valid from IP (may be combinational)
- ip_busy_o  out  1  registered back-pressure to IP
- bus_data_o  out  DW  registered beat data to bus
- bus_vld_o  out  1  registered beat valid to bus
- bus_busy_i  in  1  back-pressure from bus (may be combinational)
- occupancy_o  out  2  beats held: 0, 1 or 2
- stall_cnt_o  out  CW  saturating count of bus-stalled cycles

## Operation
- Handshake, both sides: a beat transfers in a cycle where vld=1 and busy=0. Order is preserved. No beat is dropped or duplicated.
- Storage consists of a main register, which drives bus_data_o, and a skid register.
- States (3-way, encoded in shared enum):
  - EMPTY: bus_vld_o=0, ip_busy_o=0, occupancy 0
  - ONE: bus_vld_o=1, ip_busy_o=0, occupancy 1
  - FULL: bus_vld_o=1, ip_busy_o=1, occupancy 2
- Let acc = bus_vld_o & !bus_busy_i and in = ip_vld_i & !ip_busy_o. Transitions:
  - EMPTY: if in, main <= ip_data_i and go to ONE.
  - ONE, in & acc: main <= ip_data_i, stay in ONE.
  - ONE, in & !acc: skid <= ip_data_i, go to FULL.
  - ONE, !in & acc: go to EMPTY.
  - ONE, otherwise: hold.
  - FULL: ip_vld_i is ignored. If acc, main <= skid and go to ONE; otherwise hold.
- While bus_vld_o=1 & bus_busy_i=1, bus_data_o and bus_vld_o hold their values.
- IP may change or drop ip_vld_i/ip_data_i in any cycle. Only transferring cycles are sampled.
- stall_cnt_o increments by 1 on each cycle with bus_vld_o & bus_busy_i. It saturates at 2^CW-1, with no wrap, and clears only on reset.

## Timing
- Reset values: bus_vld_o=0, bus_data_o=0, ip_busy_o=0, occupancy_o=0, stall_cnt_o=0. The skid register resets to 0 and the state to EMPTY.
- Latency: a beat accepted at edge N is visible on bus_data_o/bus_vld_o after edge N. It is first presentable to the bus in cycle N+1.
- Throughput: 1 beat/cycle sustained while bus_busy_i=0.
- ip_busy_o rises the cycle after the first stalled beat lands in skid. It falls the cycle after the bus accepts from FULL, so the IP loses exactly one cycle per stall release.
- Simultaneous input transfer and bus accept in ONE is a pass-through replace: occupancy is unchanged.
- Reset asserted mid-operation discards both held beats. Outputs take their reset values on the next edge regardless of bus_busy_i.
- All outputs are pure flop outputs, with no combinational path from any input.

## Structure
- The shared interconnect package holds the state typedef: obuf_state_t with values EMPTY, ONE, FULL.
- occupancy_o is decoded from state as registered flops, not computed from inputs.
- One sub-module, sat_cnt (parameter CW; ports inc_i, cnt_o), implements the stall counter and is reusable across interconnect blocks. Everything else is inline.

## Test plan
- Reset, then idle: all outputs 0 for 10 cycles with ip_vld_i=0.
- Stream 0x01..0x10 with bus_busy_i=0:
  - 0x01 appears on the bus one cycle after acceptance
  - 16 beats complete in 17 cycles
  - ip_busy_o stays 0
  - stall_cnt_o stays 0
- Stream 0xA0..0xA3, holding bus_busy_i=1 for 3 cycles after 0xA0 appears:
  - bus_data_o holds 0xA0
  - 0xA1 goes to skid and ip_busy_o=1
  - occupancy_o reaches 2
  - stall_cnt_o reaches 3
  - all four beats then arrive in order
- Toggle bus_busy_i randomly for 1000 beats against a scoreboard: no loss, no duplicate, order preserved, bus_data_o stable while stalled.
- Assert reset_i while in FULL (occupancy 2): next cycle bus_vld_o=0, ip_busy_o=0, occupancy_o=0, stall_cnt_o=0, and no stale beat is emitted afterwards.
- With CW=3, hold bus_busy_i=1 for 12 cycles: stall_cnt_o saturates at 7.
